// File: rtl/ecc_inv_22_16_wr_encoder.sv
// Write-side encoder for inverted SECDED(22,16) RAMs: init sweep, then a skid-buffered encode stream.
// Optional ECC_ERR_INJECT_EN adds err_inject_i, XORed into accepted codewords for decoder testing.
module ecc_inv_22_16_wr_encoder #(
    parameter int unsigned AW            = 10,
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [AW-1:0] in_addr_i,
    input  logic [15:0]   in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [AW-1:0] out_addr_o,
    output logic [21:0]   out_data_o,
    output logic          init_done_o
`ifdef ECC_ERR_INJECT_EN
    ,
    input  logic [21:0]   err_inject_i
`endif
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 6;
    localparam int unsigned WW = DW + CW;
    localparam logic [CW-1:0] CHK_INV   = 6'h2a;
    localparam logic [WW-1:0] ENC_ZERO  = 22'h2a0000;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam state_e RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

    function automatic logic [CW-1:0] calc_check(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        c[0] = ^(d & 16'h496e);
        c[1] = ^(d & 16'hf20b);
        c[2] = ^(d & 16'h8ed8);
        c[3] = ^(d & 16'h7714);
        c[4] = ^(d & 16'haca5);
        c[5] = ^(d & 16'h11f3);
        return c;
    endfunction

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [AW-1:0]   out_addr_q, out_addr_d;
    logic [WW-1:0]   out_data_q, out_data_d;
    logic            skid_valid_q, skid_valid_d;
    logic [AW-1:0]   skid_addr_q, skid_addr_d;
    logic [WW-1:0]   skid_data_q, skid_data_d;
    logic            in_ready_q, in_ready_d;
    logic            init_done_q, init_done_d;
    logic [WW-1:0]   in_cw_c;
    logic            accept_c;
    logic            out_fire_c;
    logic            out_free_c;

`ifdef ECC_ERR_INJECT_EN
    assign in_cw_c = {calc_check(in_data_i) ^ CHK_INV, in_data_i} ^ err_inject_i;
`else
    assign in_cw_c = {calc_check(in_data_i) ^ CHK_INV, in_data_i};
`endif

    assign accept_c   = in_valid_i & in_ready_q;
    assign out_fire_c = out_valid_q & out_ready_i;
    assign out_free_c = ~out_valid_q | out_fire_c;

    // Next-state: init sweep drives the output stage directly; RUN uses output reg + skid entry.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        in_ready_d   = in_ready_q;
        init_done_d  = init_done_q;
        case (state_q)
            ST_INIT: begin
                in_ready_d = 1'b0;
                if (out_fire_c && (out_addr_q == LAST_ADDR)) begin
                    state_d     = ST_RUN;
                    out_valid_d = 1'b0;
                    init_done_d = 1'b1;
                    in_ready_d  = 1'b1;
                end else if (out_free_c) begin
                    out_valid_d = 1'b1;
                    out_addr_d  = cnt_q;
                    out_data_d  = ENC_ZERO;
                    cnt_d       = cnt_q + AW'(1);
                end
            end
            ST_RUN: begin
                init_done_d = 1'b1;
                if (out_free_c) begin
                    if (skid_valid_q) begin
                        out_valid_d  = 1'b1;
                        out_addr_d   = skid_addr_q;
                        out_data_d   = skid_data_q;
                        skid_valid_d = 1'b0;
                    end else if (accept_c) begin
                        out_valid_d = 1'b1;
                        out_addr_d  = in_addr_i;
                        out_data_d  = in_cw_c;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end else if (accept_c) begin
                    skid_valid_d = 1'b1;
                    skid_addr_d  = in_addr_i;
                    skid_data_d  = in_cw_c;
                end
                in_ready_d = ~skid_valid_d;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RST_STATE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= '0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            init_done_q  <= init_done_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_addr_o  = out_addr_q;
    assign out_data_o  = out_data_q;
    assign init_done_o = init_done_q;

endmodule
